dump_fsm: RTL and testbench

DUMP_FSM -- requirements
Module: dump_fsm

---
 rtl/shake_pkg.sv | 24 ++
 rtl/dump_fsm.sv | 117 +++++++++++
 tb/tb_dump_fsm.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_pkg.sv
// Shared SHAKE output-path constants and types: word width, squeeze rates per mode, mode and FSM encodings.
package shake_pkg;

    localparam int W        = 64;
    localparam int RATE_128 = 21;
    localparam int RATE_256 = 17;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLOCK = 2'd1,
        DUMP       = 2'd2
    } state_t;

    // Number of W-bit words in one squeezed block for the given mode.
    function automatic logic [4:0] rate_words(input mode_t m);
        return (m == SHAKE256) ? 5'(RATE_256) : 5'(RATE_128);
    endfunction

endpackage

// File: rtl/dump_fsm.sv
// Drains squeezed blocks from the PISO output buffer as W-bit words on a valid/ready stream,
// requesting further squeezes until output_length bits have been delivered.
module dump_fsm
    import shake_pkg::*;
#(
    parameter int W = shake_pkg::W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        start_ready,
    input  logic [31:0] output_length,
    input  logic        mode,
    input  logic        output_buffer_ready,
    output logic        output_buffer_ready_clr,
    output logic        last_block_out,
    output logic        dump_enable,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        last_out,
    output logic [6:0]  last_word_bits,
    output logic        done,
    output state_t      fsm_state
);

    // Stream handshake: a word moves on any cycle where valid_out and ready_in are both 1;
    // valid_out never drops while waiting for ready_in, and nothing advances on a stall.

    state_t      state, state_next;
    mode_t       mode_q, mode_next;
    logic [31:0] remaining, remaining_next;
    logic [4:0]  word_cnt, word_cnt_next;
    logic        zero_done, zero_done_next;
    logic        dump_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= SHAKE128;
            remaining <= '0;
            word_cnt  <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_next;
            mode_q    <= mode_next;
            remaining <= remaining_next;
            word_cnt  <= word_cnt_next;
            zero_done <= zero_done_next;
        end
    end

    always_comb begin
        state_next              = state;
        mode_next               = mode_q;
        remaining_next          = remaining;
        word_cnt_next           = word_cnt;
        zero_done_next          = 1'b0;
        start_ready             = 1'b0;
        valid_out               = 1'b0;
        dump_enable             = 1'b0;
        last_out                = 1'b0;
        output_buffer_ready_clr = 1'b0;
        last_block_out          = 1'b0;
        dump_done               = 1'b0;

        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start) begin
                    mode_next      = mode_t'(mode);
                    remaining_next = output_length;
                    if (output_length == 32'd0) begin
                        zero_done_next = 1'b1;
                    end else begin
                        state_next = WAIT_BLOCK;
                    end
                end
            end

            WAIT_BLOCK: begin
                if (output_buffer_ready) begin
                    word_cnt_next = rate_words(mode_q);
                    state_next    = DUMP;
                end
            end

            DUMP: begin
                valid_out = 1'b1;
                last_out  = (remaining <= 32'(W));
                if (ready_in) begin
                    dump_enable    = 1'b1;
                    word_cnt_next  = word_cnt - 5'd1;
                    remaining_next = (remaining > 32'(W)) ? remaining - 32'(W) : 32'd0;
                    // The length running out ends the request even mid-block.
                    if (last_out) begin
                        output_buffer_ready_clr = 1'b1;
                        last_block_out          = 1'b1;
                        dump_done               = 1'b1;
                        state_next              = IDLE;
                    end else if (word_cnt == 5'd1) begin
                        output_buffer_ready_clr = 1'b1;
                        state_next              = WAIT_BLOCK;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign last_word_bits = (remaining[5:0] != 6'd0) ? {1'b0, remaining[5:0]} : 7'(W);
    assign done           = zero_done | dump_done;
    assign fsm_state      = state;

endmodule

// File: tb/tb_dump_fsm.sv
// Directed bench for dump_fsm: a buffer-owner model refills the PISO buffer and each request
// is drained while transfers, block releases and the final-word marking are tallied.
module tb_dump_fsm;
    import shake_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_ready;
    logic [31:0] output_length = '0;
    logic        mode = 1'b0;
    logic        obr;
    logic        output_buffer_ready_clr;
    logic        last_block_out;
    logic        dump_enable;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        last_out;
    logic [6:0]  last_word_bits;
    logic        done;
    state_t      fsm_state;

    logic        auto_load = 1'b1;
    logic        toggle_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    int n_words, n_last_idx, n_lwb, n_clr_mid, n_clr_last, n_waits;
    int n_stalls, n_bad_de, n_lastout_cyc;
    logic finished;

    dump_fsm #(.W(64)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .start_ready             (start_ready),
        .output_length           (output_length),
        .mode                    (mode),
        .output_buffer_ready     (obr),
        .output_buffer_ready_clr (output_buffer_ready_clr),
        .last_block_out          (last_block_out),
        .dump_enable             (dump_enable),
        .valid_out               (valid_out),
        .ready_in                (ready_in),
        .last_out                (last_out),
        .last_word_bits          (last_word_bits),
        .done                    (done),
        .fsm_state               (fsm_state)
    );

    always #5 clk = ~clk;

    // Buffer owner: on a mid-request release the next block is squeezed in at once.
    always @(posedge clk) begin
        if (rst)
            obr <= 1'b0;
        else if (output_buffer_ready_clr)
            obr <= !last_block_out && auto_load;
        else if (auto_load)
            obr <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_loop(input int budget);
        n_words = 0; n_last_idx = 0; n_lwb = 0; n_clr_mid = 0; n_clr_last = 0;
        n_waits = 0; n_stalls = 0; n_bad_de = 0; n_lastout_cyc = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            ready_in = toggle_ready ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (fsm_state == WAIT_BLOCK) n_waits++;
            if (valid_out && !ready_in) n_stalls++;
            if (dump_enable !== (valid_out && ready_in)) n_bad_de++;
            if (last_out) n_lastout_cyc++;
            if (dump_enable) begin
                n_words++;
                if (last_out) begin
                    n_last_idx = n_words;
                    n_lwb      = int'(last_word_bits);
                end
            end
            if (output_buffer_ready_clr) begin
                if (last_block_out) n_clr_last++;
                else n_clr_mid++;
            end
            if (done) finished = 1'b1;
            step();
        end
        chk("timeout", 64'(finished), 64'd1);
        ready_in = 1'b1;
    endtask

    task automatic do_req(input logic m, input logic [31:0] len, input int budget);
        mode          = m;
        output_length = len;
        start         = 1'b1;
        step();
        start = 1'b0;
        run_loop(budget);
    endtask

    initial begin
        int w5;
        int badw;

        // Reset state
        step();
        step();
        chk("rst_state", 64'(fsm_state), 64'(IDLE));
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_dump_en", 64'(dump_enable), 64'd0);
        chk("rst_last", 64'(last_out), 64'd0);
        chk("rst_clr", 64'(output_buffer_ready_clr), 64'd0);
        chk("rst_lbo", 64'(last_block_out), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lwb", 64'(last_word_bits), 64'd64);
        rst = 1'b0;
        ready_in = 1'b1;
        step();

        // Zero-length request
        mode = 1'b0;
        output_length = 32'd0;
        start = 1'b1;
        chk("s4_done_same", 64'(done), 64'd0);
        step();
        start = 1'b0;
        chk("s4_done", 64'(done), 64'd1);
        chk("s4_state", 64'(fsm_state), 64'(IDLE));
        chk("s4_valid", 64'(valid_out), 64'd0);
        chk("s4_clr", 64'(output_buffer_ready_clr), 64'd0);
        step();
        chk("s4_done_gone", 64'(done), 64'd0);

        // One full SHAKE128 block, continuous ready
        do_req(1'b0, 32'd1344, 200);
        chk("s1_words", 64'(n_words), 64'd21);
        chk("s1_last_idx", 64'(n_last_idx), 64'd21);
        chk("s1_lwb", 64'(n_lwb), 64'd64);
        chk("s1_clr_last", 64'(n_clr_last), 64'd1);
        chk("s1_clr_mid", 64'(n_clr_mid), 64'd0);
        chk("s1_waits", 64'(n_waits), 64'd1);
        chk("s1_de", 64'(n_bad_de), 64'd0);
        chk("s1_idle", 64'(fsm_state), 64'(IDLE));

        // SHAKE256, 2200 bits: blocks of 17, 17, 1 words
        do_req(1'b1, 32'd2200, 300);
        chk("s2_words", 64'(n_words), 64'd35);
        chk("s2_last_idx", 64'(n_last_idx), 64'd35);
        chk("s2_lwb", 64'(n_lwb), 64'd24);
        chk("s2_clr_mid", 64'(n_clr_mid), 64'd2);
        chk("s2_clr_last", 64'(n_clr_last), 64'd1);
        chk("s2_waits", 64'(n_waits), 64'd3);

        // Alternating ready_in, 256 bits
        toggle_ready = 1'b1;
        do_req(1'b0, 32'd256, 100);
        toggle_ready = 1'b0;
        chk("s3_words", 64'(n_words), 64'd4);
        chk("s3_stalls", 64'(n_stalls), 64'd4);
        chk("s3_de", 64'(n_bad_de), 64'd0);
        chk("s3_lastout_cyc", 64'(n_lastout_cyc), 64'd2);
        chk("s3_lwb", 64'(n_lwb), 64'd64);
        chk("s3_clr_last", 64'(n_clr_last), 64'd1);

        // Short requests with partial final words
        do_req(1'b1, 32'd100, 50);
        chk("p100_words", 64'(n_words), 64'd2);
        chk("p100_lwb", 64'(n_lwb), 64'd36);
        do_req(1'b0, 32'd1, 50);
        chk("p1_words", 64'(n_words), 64'd1);
        chk("p1_lwb", 64'(n_lwb), 64'd1);
        chk("p1_clr_last", 64'(n_clr_last), 64'd1);

        // Reset mid-DUMP after the fifth word
        mode = 1'b0;
        output_length = 32'd1344;
        start = 1'b1;
        step();
        start = 1'b0;
        w5 = 0;
        for (int c = 0; c < 40 && w5 < 5; c++) begin
            #1;
            if (dump_enable) w5++;
            step();
        end
        chk("s5_w5", 64'(w5), 64'd5);
        rst = 1'b1;
        #1;
        chk("s5_valid_in_rst", 64'(valid_out), 64'd1);
        chk("s5_no_clr", 64'(output_buffer_ready_clr), 64'd0);
        step();
        chk("s5_state", 64'(fsm_state), 64'(IDLE));
        chk("s5_start_ready", 64'(start_ready), 64'd1);
        chk("s5_valid", 64'(valid_out), 64'd0);
        chk("s5_de", 64'(dump_enable), 64'd0);
        chk("s5_last", 64'(last_out), 64'd0);
        chk("s5_clr", 64'(output_buffer_ready_clr), 64'd0);
        chk("s5_done", 64'(done), 64'd0);
        chk("s5_lwb", 64'(last_word_bits), 64'd64);
        rst = 1'b0;
        step();
        do_req(1'b0, 32'd1344, 200);
        chk("s5_re_words", 64'(n_words), 64'd21);
        chk("s5_re_clr_last", 64'(n_clr_last), 64'd1);

        // Buffer held empty for 10 cycles; a stray start meanwhile is ignored
        auto_load = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode = 1'b0;
        output_length = 32'd128;
        start = 1'b1;
        step();
        start = 1'b0;
        badw = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            output_length = (c == 3) ? 32'd0 : 32'd128;
            #1;
            if (valid_out !== 1'b0 || fsm_state != WAIT_BLOCK || done !== 1'b0) badw++;
            step();
        end
        start = 1'b0;
        chk("s6_hold", 64'(badw), 64'd0);
        auto_load = 1'b1;
        step();
        chk("s6_still_wait", 64'(fsm_state), 64'(WAIT_BLOCK));
        chk("s6_valid_low", 64'(valid_out), 64'd0);
        step();
        chk("s6_dump", 64'(fsm_state), 64'(DUMP));
        chk("s6_valid", 64'(valid_out), 64'd1);
        run_loop(20);
        chk("s6_words", 64'(n_words), 64'd2);
        chk("s6_lwb", 64'(n_lwb), 64'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
